write_back_memory_controller: RTL and testbench

Main-memory stage directly downstream of the two-way fully associative cache. Takes dirty-block evictions (write requests) and miss fills (read requests) from the cache, buffers evictions in a small write-back FIFO, and serves both against a 32×8 backing memory with a fixed access latency. Reads that hit a buffered eviction are forwarded without touching memory.

---
 rtl/memctl_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/write_back_memory_controller.sv | 212 +++++++++++++++++++++
 tb/tb_write_back_memory_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/memctl_pkg.sv
// Shared types and default sizes for the write-back memory controller.
package memctl_pkg;

  localparam int MEMCTL_ADDR_W     = 5;
  localparam int MEMCTL_DATA_W     = 8;
  localparam int MEMCTL_WBUF_DEPTH = 2;
  localparam int MEMCTL_MEM_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } memctl_state_e;

  typedef struct packed {
    logic [MEMCTL_ADDR_W-1:0] tag;
    logic [MEMCTL_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back FIFO: circular buffer of {tag, data} evictions with age-ordered
// parallel views (slot k = k-th oldest entry) for the read tag search.
module wb_fifo
  import memctl_pkg::*;
#(
  parameter int ADDR_W = MEMCTL_ADDR_W,
  parameter int DATA_W = MEMCTL_DATA_W,
  parameter int DEPTH  = MEMCTL_WBUF_DEPTH
) (
  input  logic                     clock1,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_tag,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [ADDR_W-1:0]        head_tag,
  output logic [DATA_W-1:0]        head_data,
  output logic [DEPTH*ADDR_W-1:0]  age_tags,
  output logic [DEPTH*DATA_W-1:0]  age_data,
  output logic [DEPTH-1:0]         age_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] tag_mem_r  [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [CW-1:0]     count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_tag  = tag_mem_r[rptr_r];
  assign head_data = data_mem_r[rptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clock1) begin
    if (Reset) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_r[i]  <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        tag_mem_r[wptr_r]  <= push_tag;
        data_mem_r[wptr_r] <= push_data;
        wptr_r             <= wptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Age-ordered views of the buffer for the forwarding / hazard search
  always_comb begin
    age_tags  = {(DEPTH*ADDR_W){1'b0}};
    age_data  = {(DEPTH*DATA_W){1'b0}};
    age_valid = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      age_tags[k*ADDR_W +: ADDR_W] = tag_mem_r[rptr_r + PW'(k)];
      age_data[k*DATA_W +: DATA_W] = data_mem_r[rptr_r + PW'(k)];
      age_valid[k]                 = (CW'(k) < count_r);
    end
  end

endmodule

// File: rtl/write_back_memory_controller.sv
// Backing-memory stage behind the cache: buffers evictions, serves fills.
// Define MEMCTL_FORWARD_EN to forward fills from buffered evictions.
module write_back_memory_controller
  import memctl_pkg::*;
#(
  parameter int ADDR_W     = MEMCTL_ADDR_W,
  parameter int DATA_W     = MEMCTL_DATA_W,
  parameter int WBUF_DEPTH = MEMCTL_WBUF_DEPTH,
  parameter int MEM_LAT    = MEMCTL_MEM_LAT
) (
  input  logic              clock1,
  input  logic              Reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int LW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

`ifdef MEMCTL_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  memctl_state_e state_r;
  memctl_state_e state_nxt_s;
  logic [LW-1:0] lat_cnt_r;
  logic          lat_last_s;

  logic [DATA_W-1:0] mem_r [MEM_WORDS];

  logic [ADDR_W-1:0] tag_r;
  logic              fwd_r;
  logic [DATA_W-1:0] fwd_data_r;
  logic              rd_ready_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;

  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [ADDR_W-1:0] pend_tag_s;
  logic              match_any_s;
  logic [DATA_W-1:0] fwd_data_s;
  logic              fwd_hit_s;
  logic              blocked_s;
  logic              pend_mem_s;
  logic              read_go_s;
  logic              pop_s;
  logic              rd_done_s;

  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic [ADDR_W-1:0]            head_tag_s;
  logic [DATA_W-1:0]            head_data_s;
  logic [WBUF_DEPTH*ADDR_W-1:0] age_tags_s;
  logic [WBUF_DEPTH*DATA_W-1:0] age_data_s;
  logic [WBUF_DEPTH-1:0]        age_valid_s;

  wb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wb_fifo (
    .clock1    (clock1),
    .Reset     (Reset),
    .push      (wr_acc_s),
    .push_tag  (wr_tag),
    .push_data (wr_data),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_tag  (head_tag_s),
    .head_data (head_data_s),
    .age_tags  (age_tags_s),
    .age_data  (age_data_s),
    .age_valid (age_valid_s)
  );

  assign wr_acc_s   = wr_req && !fifo_full_s;
  assign rd_acc_s   = rd_req && rd_ready_r;
  assign pend_tag_s = rd_acc_s ? rd_tag : tag_r;
  assign lat_last_s = (lat_cnt_r == LAT_LAST);

  assign wr_ready = !fifo_full_s;
  assign rd_ready = rd_ready_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign busy     = (state_r != IDLE) || !fifo_empty_s;

  // Buffer search, oldest to newest so the newest match (incl. a same-edge push) wins
  always_comb begin
    match_any_s = 1'b0;
    fwd_data_s  = {DATA_W{1'b0}};
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      match_any_s = (age_valid_s[k] && (age_tags_s[k*ADDR_W +: ADDR_W] == pend_tag_s))
                    ? 1'b1 : match_any_s;
      fwd_data_s  = (age_valid_s[k] && (age_tags_s[k*ADDR_W +: ADDR_W] == pend_tag_s))
                    ? age_data_s[k*DATA_W +: DATA_W] : fwd_data_s;
    end
    match_any_s = (wr_acc_s && (wr_tag == pend_tag_s)) ? 1'b1 : match_any_s;
    fwd_data_s  = (wr_acc_s && (wr_tag == pend_tag_s)) ? wr_data : fwd_data_s;
  end

  // Without forwarding, a read aliasing a buffered eviction must wait for the buffer to empty
  assign fwd_hit_s  = FWD_EN && rd_acc_s && match_any_s;
  assign blocked_s  = !FWD_EN && match_any_s;
  assign pend_mem_s = (rd_acc_s && !fwd_hit_s) || (!rd_ready_r && !fwd_r);
  assign read_go_s  = pend_mem_s && !blocked_s;

  // Next-state and per-state strobes
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    rd_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (read_go_s) begin
          state_nxt_s = READ;
        end else if (!fifo_empty_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (lat_last_s) begin
          state_nxt_s = IDLE;
          rd_done_s   = 1'b1;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (lat_last_s) begin
          state_nxt_s = IDLE;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and access-latency counter
  always_ff @(posedge clock1) begin
    if (Reset) begin
      state_r   <= IDLE;
      lat_cnt_r <= {LW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) || lat_last_s) begin
        lat_cnt_r <= {LW{1'b0}};
      end else begin
        lat_cnt_r <= lat_cnt_r + LW'(1);
      end
    end
  end

  // Fill request bookkeeping and registered read response
  always_ff @(posedge clock1) begin
    if (Reset) begin
      tag_r      <= {ADDR_W{1'b0}};
      fwd_r      <= 1'b0;
      fwd_data_r <= {DATA_W{1'b0}};
      rd_ready_r <= 1'b1;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= 1'b0;
      if (rd_acc_s) begin
        tag_r      <= rd_tag;
        fwd_r      <= fwd_hit_s;
        fwd_data_r <= fwd_data_s;
        rd_ready_r <= 1'b0;
      end else if (fwd_r) begin
        fwd_r      <= 1'b0;
        rd_ready_r <= 1'b1;
        rd_valid_r <= 1'b1;
        rd_data_r  <= fwd_data_r;
      end else if (rd_done_s) begin
        rd_ready_r <= 1'b1;
        rd_valid_r <= 1'b1;
        rd_data_r  <= mem_r[tag_r];
      end
    end
  end

  // Backing memory: identity image on reset, head entry committed on each pop
  always_ff @(posedge clock1) begin
    if (Reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_r[i] <= DATA_W'(i);
      end
    end else if (pop_s) begin
      mem_r[head_tag_s] <= head_data_s;
    end
  end

endmodule

// File: tb/tb_write_back_memory_controller.sv
// Directed self-checking bench for write_back_memory_controller (either MEMCTL_FORWARD_EN build).
module tb_write_back_memory_controller;

  logic       clock1 = 1'b0;
  logic       Reset  = 1'b1;
  logic       wr_req = 1'b0;
  logic [4:0] wr_tag = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic       rd_req = 1'b0;
  logic [4:0] rd_tag = 5'd0;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  always #5 clock1 = ~clock1;

  write_back_memory_controller dut (
    .clock1   (clock1),
    .Reset    (Reset),
    .wr_req   (wr_req),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_tag   (rd_tag),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clock1);
    #1;
  endtask

  task automatic apply_reset();
    Reset  = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Returns with the write accepted on the last edge; ok=0 if wr_ready never rose.
  task automatic do_write(input logic [4:0] tag, input logic [7:0] data, output bit ok);
    int n = 0;
    while (!wr_ready && n < 40) begin
      tick();
      n++;
    end
    ok = wr_ready;
    wr_req  = 1'b1;
    wr_tag  = tag;
    wr_data = data;
    tick();
    wr_req = 1'b0;
  endtask

  // lat = edges from acceptance edge to first rd_valid sample, -1 on timeout.
  task automatic do_read(input logic [4:0] tag, output int lat, output logic [7:0] data);
    int n = 0;
    while (!rd_ready && n < 40) begin
      tick();
      n++;
    end
    rd_req = 1'b1;
    rd_tag = tag;
    tick();
    rd_req = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 60) begin
      tick();
      lat++;
    end
    data = rd_data;
    if (!rd_valid) lat = -1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_ready !== 1'b1) begin fails++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_read_mem();
    apply_reset();
    rd_req = 1'b1;
    rd_tag = 5'd5;
    tick();
    rd_req = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rdmem_busy_during got %b want 1", busy); end
    checks++; if (rd_ready !== 1'b0) begin fails++; $display("FAIL rdmem_rd_ready_low got %b want 0", rd_ready); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rdmem_early_valid got %b want 0", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL rdmem_valid_at_2 got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h05) begin fails++; $display("FAIL rdmem_data got %h want 05", rd_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rdmem_busy_after got %b want 0", busy); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rdmem_pulse_width got %b want 0", rd_valid); end
  endtask

  task automatic test_forward();
    bit ok;
    int lat;
    int exp_lat;
    logic [7:0] d;
`ifdef MEMCTL_FORWARD_EN
    exp_lat = 1;
`else
    exp_lat = 5;   // drain (IDLE + 2) then IDLE decision + 2-cycle read
`endif
    apply_reset();
    do_write(5'd3, 8'hA7, ok);
    checks++; if (!ok) begin fails++; $display("FAIL fwd_write_ready got 0 want 1"); end
    do_read(5'd3, lat, d);
    checks++; if (lat != exp_lat) begin fails++; $display("FAIL fwd_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (d !== 8'hA7) begin fails++; $display("FAIL fwd_data got %h want a7", d); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rejected = 0;
    int lat;
    logic [7:0] d;
    apply_reset();
    do_write(5'd1, 8'h31, ok);
    do_write(5'd2, 8'h32, ok);
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_wr_ready got %b want 0", wr_ready); end
    wr_req  = 1'b1;
    wr_tag  = 5'd7;
    wr_data = 8'h77;
    while (!wr_ready && rejected < 20) begin
      tick();
      rejected++;
    end
    tick();
    wr_req = 1'b0;
    checks++; if (rejected != 2) begin fails++; $display("FAIL b2b_reject_cycles got %0d want 2", rejected); end
    do_read(5'd1, lat, d);
    checks++; if (d !== 8'h31 || lat < 0) begin fails++; $display("FAIL b2b_read1 got %h lat %0d want 31", d, lat); end
    do_read(5'd2, lat, d);
    checks++; if (d !== 8'h32 || lat < 0) begin fails++; $display("FAIL b2b_read2 got %h lat %0d want 32", d, lat); end
    do_read(5'd7, lat, d);
    checks++; if (d !== 8'h77 || lat < 0) begin fails++; $display("FAIL b2b_read7 got %h lat %0d want 77", d, lat); end
  endtask

  task automatic test_duplicate_tag();
    bit ok;
    int n = 0;
    int lat;
    logic [7:0] d;
    apply_reset();
    do_write(5'd4, 8'h11, ok);
    do_write(5'd4, 8'h22, ok);
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL dup_drain_idle got %b want 0", busy); end
    do_read(5'd4, lat, d);
    checks++; if (lat != 2) begin fails++; $display("FAIL dup_mem_latency got %0d want 2", lat); end
    checks++; if (d !== 8'h22) begin fails++; $display("FAIL dup_data got %h want 22", d); end
  endtask

  task automatic test_read_mid_drain();
    bit ok;
    int lat;
    logic [7:0] d;
    apply_reset();
    do_write(5'd12, 8'h5C, ok);
    tick();   // now in DRAIN, first latency cycle
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL middrain_busy got %b want 1", busy); end
    do_read(5'd9, lat, d);
    checks++; if (lat != 4) begin fails++; $display("FAIL middrain_latency got %0d want 4", lat); end
    checks++; if (d !== 8'h09) begin fails++; $display("FAIL middrain_data got %h want 09", d); end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int lat;
    logic [7:0] d;
    apply_reset();
    do_read(5'd10, lat, d);
    checks++; if (d !== 8'h0A) begin fails++; $display("FAIL rstdrain_pre_read got %h want 0a", d); end
    do_write(5'd6, 8'hFF, ok);
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL rstdrain_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_ready !== 1'b1) begin fails++; $display("FAIL rstdrain_rd_ready got %b want 1", rd_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rstdrain_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin fails++; $display("FAIL rstdrain_rd_data got %h want 00", rd_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstdrain_busy got %b want 0", busy); end
    Reset = 1'b0;
    do_read(5'd6, lat, d);
    checks++; if (lat != 2) begin fails++; $display("FAIL rstdrain_latency got %0d want 2", lat); end
    checks++; if (d !== 8'h06) begin fails++; $display("FAIL rstdrain_data got %h want 06", d); end
  endtask

  initial begin
    test_reset();
    test_read_mem();
    test_forward();
    test_back_to_back();
    test_duplicate_tag();
    test_read_mid_drain();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
